// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: shared state encoding, command-byte layout and sizes for spi_reg_ctrl
package spi_reg_pkg;
  localparam int WIDTH = 8;
  localparam logic [1:0] ADDR_STATUS = 2'd3;
  localparam int CMD_WR_BIT = 7;
  localparam int CMD_CLR_BIT = 6;
  localparam int CMD_RSV_HI = 5;
  localparam int CMD_RSV_LO = 2;
  typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} state_t;
endpackage

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: SPI byte-stream register file with burst read/write, status readback and sticky error
module spi_reg_ctrl #(
  parameter int WIDTH = 8,
  parameter int NRW = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cs_active,
  input  logic                   rx_valid,
  input  logic [WIDTH-1:0]       rx_data,
  output logic [WIDTH-1:0]       tx_data,
  input  logic [WIDTH-1:0]       status_in,
  output logic [NRW*WIDTH-1:0]   regs_out,
  output logic                   wr_stb,
  output logic [1:0]             wr_addr,
  output logic                   err,
  output logic                   busy
);
  import spi_reg_pkg::*;
  state_t state_q, state_d;
  logic [1:0] ptr_q, ptr_d, wr_addr_q, wr_addr_d, rd_a;
  logic [NRW-1:0][WIDTH-1:0] regs_q, regs_d;
  logic [WIDTH-1:0] tx_q, tx_d, rd_v;
  logic wr_stb_q, wr_stb_d, err_q, err_d, hold_q, hold_d;
  // the command byte reads its own address; bursts read at the pointer
  assign rd_a = (state_q == CMD) ? rx_data[1:0] : ptr_q;
  assign rd_v = (rd_a == ADDR_STATUS) ? status_in : regs_q[rd_a];
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    regs_d = regs_q;
    tx_d = tx_q;
    wr_stb_d = 1'b0;
    wr_addr_d = wr_addr_q;
    err_d = err_q;
    hold_d = hold_q;
    case (state_q)
      IDLE: if (cs_active && !hold_q) begin
        state_d = CMD;
        tx_d = {err_q, {(WIDTH-1){1'b0}}};
      end
      CMD: if (rx_valid) begin
        if (|rx_data[CMD_RSV_HI:CMD_RSV_LO]) begin
          err_d = 1'b1;
          hold_d = 1'b1;
          state_d = IDLE;
        end else begin
          err_d = rx_data[CMD_CLR_BIT] ? 1'b0 : err_q;
          state_d = rx_data[CMD_WR_BIT] ? WRITE : READ;
          ptr_d = rx_data[CMD_WR_BIT] ? rx_data[1:0] : rx_data[1:0] + 2'd1;
          tx_d = rx_data[CMD_WR_BIT] ? tx_q : rd_v;
        end
      end
      WRITE: if (rx_valid) begin
        if (ptr_q != ADDR_STATUS) begin
          regs_d[ptr_q] = rx_data;
          wr_stb_d = 1'b1;
          wr_addr_d = ptr_q;
        end else begin
          err_d = 1'b1;
        end
        ptr_d = ptr_q + 2'd1;
      end
      READ: if (rx_valid) begin
        tx_d = rd_v;
        ptr_d = ptr_q + 2'd1;
      end
      default: state_d = IDLE;
    endcase
    // a byte arriving with the chip-select fall is still applied above
    if (!cs_active) begin
      state_d = IDLE;
      ptr_d = 2'd0;
      hold_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      regs_q <= '0;
      tx_q <= '0;
      wr_stb_q <= 1'b0;
      wr_addr_q <= '0;
      err_q <= 1'b0;
      hold_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      regs_q <= regs_d;
      tx_q <= tx_d;
      wr_stb_q <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      err_q <= err_d;
      hold_q <= hold_d;
    end
  end
  assign tx_data = tx_q;
  assign regs_out = regs_q;
  assign wr_stb = wr_stb_q;
  assign wr_addr = wr_addr_q;
  assign err = err_q;
  assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb_spi_reg_ctrl: directed and randomized transactions against a byte-level behavioural model
module tb_spi_reg_ctrl;
  logic clk = 1'b0;
  logic reset, cs_active, rx_valid, wr_stb, err, busy;
  logic [7:0] rx_data, tx_data, status_in;
  logic [23:0] regs_out;
  logic [1:0] wr_addr;
  int n_chk = 0, n_pass = 0;
  logic [7:0] m_regs [3];
  logic [7:0] m_tx;
  logic m_err, m_stb;
  int m_ptr, m_waddr, m_mode;
  localparam int M_IDLE = 0, M_CMD = 1, M_WR = 2, M_RD = 3, M_DEAD = 4;

  spi_reg_ctrl dut (
    .clk(clk), .reset(reset), .cs_active(cs_active), .rx_valid(rx_valid),
    .rx_data(rx_data), .tx_data(tx_data), .status_in(status_in),
    .regs_out(regs_out), .wr_stb(wr_stb), .wr_addr(wr_addr), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] m_rd(input int a);
    return (a == 3) ? status_in : m_regs[a];
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".tx"}, {24'd0, tx_data}, {24'd0, m_tx});
    check({tag, ".regs"}, {8'd0, regs_out}, {8'd0, m_regs[2], m_regs[1], m_regs[0]});
    check({tag, ".err"}, {31'd0, err}, {31'd0, m_err});
    check({tag, ".stb"}, {31'd0, wr_stb}, {31'd0, m_stb});
    check({tag, ".waddr"}, {30'd0, wr_addr}, m_waddr);
    if (m_mode != M_DEAD) check({tag, ".busy"}, {31'd0, busy}, {31'd0, m_mode != M_IDLE});
  endtask

  task automatic model_byte(input logic [7:0] b);
    m_stb = 1'b0;
    if (m_mode == M_CMD) begin
      if (b[5:2] != 4'd0) begin
        m_err = 1'b1;
        m_mode = M_DEAD;
      end else begin
        if (b[6]) m_err = 1'b0;
        if (b[7]) begin
          m_mode = M_WR;
          m_ptr = b[1:0];
        end else begin
          m_mode = M_RD;
          m_tx = m_rd(b[1:0]);
          m_ptr = (b[1:0] + 1) % 4;
        end
      end
    end else if (m_mode == M_WR) begin
      if (m_ptr < 3) begin
        m_regs[m_ptr] = b;
        m_stb = 1'b1;
        m_waddr = m_ptr;
      end else m_err = 1'b1;
      m_ptr = (m_ptr + 1) % 4;
    end else if (m_mode == M_RD) begin
      m_tx = m_rd(m_ptr);
      m_ptr = (m_ptr + 1) % 4;
    end
  endtask

  task automatic send(input string tag, input logic [7:0] b, input bit drop);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data = b;
    if (drop) cs_active = 1'b0;
    @(negedge clk);
    rx_valid = 1'b0;
    model_byte(b);
    if (drop) m_mode = M_IDLE;
    check_all(tag);
  endtask

  task automatic open_cs(input string tag);
    @(negedge clk);
    cs_active = 1'b1;
    @(negedge clk);
    m_tx = {m_err, 7'd0};
    m_mode = M_CMD;
    m_stb = 1'b0;
    check_all(tag);
  endtask

  task automatic close_cs(input string tag);
    @(negedge clk);
    cs_active = 1'b0;
    @(negedge clk);
    m_mode = M_IDLE;
    m_stb = 1'b0;
    check_all(tag);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_regs[i] = 8'd0;
    m_tx = 8'd0;
    m_err = 1'b0;
    m_stb = 1'b0;
    m_waddr = 0;
    m_ptr = 0;
    m_mode = M_IDLE;
  endtask

  initial begin
    reset = 1'b1;
    cs_active = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'd0;
    status_in = 8'd0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    reset = 1'b0;
    open_cs("wb.open");
    send("wb.cmd", 8'h80, 1'b0);
    send("wb.d0", 8'h11, 1'b0);
    send("wb.d1", 8'h22, 1'b0);
    send("wb.d2", 8'h33, 1'b0);
    close_cs("wb.close");
    status_in = 8'h5A;
    open_cs("rd.open");
    send("rd.cmd", 8'h02, 1'b0);
    send("rd.x0", 8'hC3, 1'b0);
    send("rd.x1", 8'h9E, 1'b0);
    send("rd.x2", 8'h01, 1'b0);
    close_cs("rd.close");
    open_cs("ro.open");
    send("ro.cmd", 8'h83, 1'b0);
    send("ro.d", 8'h77, 1'b0);
    close_cs("ro.close");
    open_cs("ro.next");
    close_cs("ro.next_close");
    open_cs("clr.open");
    send("clr.cmd", 8'h40, 1'b0);
    close_cs("clr.close");
    open_cs("rsv.open");
    send("rsv.cmd", 8'h04, 1'b0);
    send("rsv.x0", 8'h81, 1'b0);
    send("rsv.x1", 8'h55, 1'b0);
    close_cs("rsv.close");
    open_cs("set_clr.open");
    send("set_clr.cmd", 8'h44, 1'b0);
    close_cs("set_clr.close");
    open_cs("ab.open");
    send("ab.cmd", 8'h80, 1'b0);
    send("ab.d0", 8'hA5, 1'b0);
    send("ab.d1", 8'hB6, 1'b1);
    send("idle.byte", 8'h81, 1'b0);
    open_cs("rst.open");
    send("rst.cmd", 8'h01, 1'b0);
    send("rst.x0", 8'h00, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    model_reset();
    check_all("rst.mid");
    reset = 1'b0;
    cs_active = 1'b0;
    @(negedge clk);
    for (int t = 0; t < 60; t++) begin
      logic [7:0] cmd;
      int n;
      bit dropped;
      dropped = 1'b0;
      open_cs("rnd.open");
      cmd = ($urandom_range(0, 5) == 0) ? 8'($urandom) :
            {1'($urandom), ($urandom_range(0, 3) == 0), 4'd0, 2'($urandom)};
      status_in = 8'($urandom);
      send("rnd.cmd", cmd, 1'b0);
      n = $urandom_range(0, 6);
      for (int i = 0; i < n && !dropped; i++) begin
        status_in = 8'($urandom);
        dropped = ($urandom_range(0, 7) == 0);
        send("rnd.byte", 8'($urandom), dropped);
      end
      if (!dropped) close_cs("rnd.close");
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
